hs_slave_fifo: RTL and testbench
================================

# hs_slave_fifo

Downstream buffering stage between the round-robin arbiter's per-slave output channel (`out_data_sN`/`out_valid_sN`/`in_ready_sN`) and a handshake slave. It accepts 8-bit beats on a valid/ready interface, stores up to DEPTH beats in order, and presents them first-word-fall-through to the consumer. The arbiter can complete grants while the slave stalls. Occupancy flags and a beat counter are exported for arbitration monitoring and testbench checks.

## Interface
Parameters:
- `DATA_W`, 8, beat width.
- `DEPTH`, 4, entry count; power of two, at least 2.
- `PTR_W`, 2, log2(DEPTH); set consistently with DEPTH.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset asserted); release is synchronous to `clk` externally.
- `in_valid`  in  1  upstream (arbiter) beat valid.
- `in_data`  in  DATA_W  upstream beat.
- `in_ready`  out  1  FIFO can accept a beat.
- `out_valid`  out  1  head beat available.
- `out_data`  out  DATA_W  head beat; 0 when empty.
- `out_ready`  in  1  consumer accepts head.
- `count`  out  PTR_W+1  current occupancy, 0..DEPTH.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `beat_cnt`  out  16  total beats accepted since reset; wraps 0xFFFF to 0x0000.

## Operation
- Storage: DEPTH x DATA_W register array, write pointer `wr_ptr`, read pointer `rd_ptr` (PTR_W bits each, natural wrap DEPTH-1 to 0), occupancy register `count`.
- Push: `in_valid && in_ready` at the clock edge. Writes `in_data` to `mem[wr_ptr]`, increments `wr_ptr` and `beat_cnt`.
- Pop: `out_valid && out_ready` at the clock edge. Increments `rd_ptr`.
- Count update: push only +1; pop only -1; both 0; neither 0.
- `in_ready = !full`. It depends only on registered state, never on `out_ready`, so there is no combinational ready path through the block.
- `out_valid = !empty`. `out_data = mem[rd_ptr]` when not empty, else 0.
- Occupancy state, derived from `count`:
  - EMPTY (0): push goes to PARTIAL (or FULL if DEPTH were 1, which is disallowed).
  - PARTIAL (1..DEPTH-1): push only increments; pop only decrements; push+pop holds.
  - FULL (DEPTH): a pop moves to PARTIAL. A push is impossible because `in_ready` = 0.
- Simultaneous push and pop in EMPTY: cannot occur because `out_valid` = 0, so only the push takes effect.
- Simultaneous push and pop in FULL: only the pop takes effect. The offered beat stays pending upstream, and `in_ready` rises the next cycle.
- Data order is strictly FIFO. No beat is dropped or duplicated.
- `in_data` is ignored when `in_valid` = 0. `in_valid` dropping without a handshake is legal and leaves state unchanged.

## Timing
- Reset (`rst` = 0, asynchronous) forces immediately:
  - `wr_ptr`, `rd_ptr`, `count`, `beat_cnt` = 0;
  - `in_ready` = 1; `out_valid` = 0; `out_data` = 0;
  - `full` = 0; `empty` = 1.
- Memory contents are not cleared.
- Reset mid-operation discards all stored beats. A beat offered in the same cycle reset is asserted is not accepted.
- Push-to-output latency: a beat pushed at edge N into an empty FIFO is on `out_data` with `out_valid` = 1 after edge N, and can be popped at edge N+1.
- Throughput: one push and one pop per cycle in PARTIAL. Sustained 1 beat/cycle with DEPTH >= 2.
- `count`, `full`, `empty`, `beat_cnt` are registered and reflect the edge just taken.
- Wrap-around: after DEPTH pushes, `wr_ptr` returns to 0. Ordering is preserved across pointer wrap.

## Test plan
- Reset: drive `rst` = 0 mid-stream with 3 beats stored. Required: `count` = 0, `empty` = 1, `out_valid` = 0, `out_data` = 0x00, `beat_cnt` = 0 immediately, without waiting for a clock edge.
- Single beat: from empty, push 0xAA with `out_ready` = 0. Required: one cycle later `out_valid` = 1, `out_data` = 0xAA, `count` = 1. Then raise `out_ready`; one cycle later `empty` = 1.
- Fill and stall: hold `out_ready` = 0 and offer 0xAA, 0xBB, 0xCC, 0xDD, 0xEE. Required:
  - after 4 accepts, `full` = 1, `in_ready` = 0;
  - 0xEE stays pending;
  - `beat_cnt` = 4.
- Full push+pop: with FIFO full and 0xEE offered, raise `out_ready` for 1 cycle. Required: 0xAA popped, `count` = 3. Then 0xEE is accepted on the next edge, and drain order is 0xBB, 0xCC, 0xDD, 0xEE.
- Streaming wrap: hold `in_valid` = `out_ready` = 1 for 10 beats 0x55..0x5E. Required: `count` stays at 1 after the first edge, outputs are 0x55..0x5E in order across two pointer wraps, and `beat_cnt` = 10.
- Arbiter integration: connect behind arbiter slave 1. Send requests `req_sigs` = 2'b01, address 0xAA, data 0xAA/0xBB/0xCC while the slave stalls. Required: all three beats are delivered in order once the slave's ready is raised.

Source files
------------

// File: rtl/hs_slave_fifo_if.sv
// Handshake bundle between the arbiter's per-slave channel, the FIFO and the consumer.
// master: the environment side (drives upstream beats and downstream ready).
// slave:  the FIFO side (accepts upstream beats, presents head beat).
interface hs_slave_fifo_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/hs_slave_fifo.sv
// First-word-fall-through buffering stage behind an arbiter slave channel.
// Stores up to DEPTH beats in order; ready/valid depend only on registered state,
// so there is no combinational path from out_ready to in_ready.
module hs_slave_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,  // power of two, >= 2
  parameter int unsigned PTR_W  = 2   // must equal log2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,       // asynchronous, active-low
  hs_slave_fifo_if.slave   bus,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty,
  output logic [15:0]      beat_cnt
);

  localparam logic [PTR_W:0] CntOne  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0] CntLast = (PTR_W + 1)'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PtrOne = PTR_W'(1);
  localparam logic [15:0]    BeatOne = 16'd1;

  // Occupancy class; kept in step with count_q so full/empty come straight from a register.
  typedef enum logic [1:0] {
    StEmpty,
    StPartial,
    StFull
  } occ_e;

  occ_e                state_q, state_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      count_q, count_d;
  logic [15:0]         beat_cnt_q, beat_cnt_d;
  logic                push, pop;

  // Handshake outputs derived from registered occupancy only.
  always_comb begin
    full          = (state_q == StFull);
    empty         = (state_q == StEmpty);
    bus.in_ready  = ~full;
    bus.out_valid = ~empty;
    bus.out_data  = empty ? '0 : mem[rd_ptr_q];
    count         = count_q;
    beat_cnt      = beat_cnt_q;
    push          = bus.in_valid & bus.in_ready;
    pop           = bus.out_valid & bus.out_ready;
  end

  // Pointer, occupancy and beat counter next-state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    beat_cnt_d = beat_cnt_q;
    if (push) begin
      wr_ptr_d   = wr_ptr_q + PtrOne;
      beat_cnt_d = beat_cnt_q + BeatOne;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  // Occupancy FSM next-state: transitions only at the count boundaries.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: begin
        // pop is impossible here since out_valid is low
        if (push) state_d = StPartial;
      end
      StPartial: begin
        if (push && !pop && (count_q == CntLast)) state_d = StFull;
        else if (pop && !push && (count_q == CntOne)) state_d = StEmpty;
      end
      StFull: begin
        // push is impossible here since in_ready is low
        if (pop) state_d = StPartial;
      end
      default: state_d = StEmpty;
    endcase
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StEmpty;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Storage array; deliberately not reset, stale contents are masked by empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.in_data;
    end
  end

endmodule

// File: tb/tb_hs_slave_fifo.sv
// Self-checking bench for hs_slave_fifo: directed table, hand-written corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_hs_slave_fifo;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic [15:0] beat_cnt;

  int checks;
  int failures;

  hs_slave_fifo_if #(.DATA_W(8)) bus ();

  hs_slave_fifo #(
    .DATA_W(8),
    .DEPTH (DEPTH),
    .PTR_W (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .beat_cnt(beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain queue of stored beats plus an accepted-beat counter.
  logic [7:0]  mq[$];
  logic [15:0] mbeat;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       r;
    int         exp_count;
    logic [7:0] exp_data;
    logic       exp_full;
    logic       exp_empty;
    int         exp_beat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
  endtask

  // Apply reset across one edge, then release away from the edge.
  task automatic do_reset();
    drive(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    mq.delete();
    mbeat = 16'd0;
  endtask

  // One cycle of traffic checked against the reference model.
  task automatic model_step(input logic v, input logic [7:0] d, input logic r);
    logic do_push;
    logic do_pop;
    drive(v, d, r);
    do_push = v && (mq.size() < DEPTH);
    do_pop  = r && (mq.size() > 0);
    @(posedge clk);
    #1;
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      mq.push_back(d);
      mbeat = mbeat + 16'd1;
    end
    chk("rand_count", 32'(count), 32'(mq.size()));
    chk("rand_full", 32'(full), 32'(mq.size() == DEPTH));
    chk("rand_empty", 32'(empty), 32'(mq.size() == 0));
    chk("rand_in_ready", 32'(bus.in_ready), 32'(mq.size() != DEPTH));
    chk("rand_out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
    chk("rand_out_data", 32'(bus.out_data), 32'((mq.size() != 0) ? mq[0] : 8'h00));
    chk("rand_beat_cnt", 32'(beat_cnt), 32'(mbeat));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    mbeat    = 16'd0;

    // Reset values visible before any clock edge.
    #2;
    chk("rst0_count", 32'(count), 32'd0);
    chk("rst0_empty", 32'(empty), 32'd1);
    chk("rst0_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst0_out_data", 32'(bus.out_data), 32'h00);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Directed table: fill/stall, full push+pop, drain order, single beat, ignored data.
    vecs.push_back('{1'b1, 8'hAA, 1'b0, 1, 8'hAA, 1'b0, 1'b0, 1});
    vecs.push_back('{1'b1, 8'hBB, 1'b0, 2, 8'hAA, 1'b0, 1'b0, 2});
    vecs.push_back('{1'b1, 8'hCC, 1'b0, 3, 8'hAA, 1'b0, 1'b0, 3});
    vecs.push_back('{1'b1, 8'hDD, 1'b0, 4, 8'hAA, 1'b1, 1'b0, 4});
    vecs.push_back('{1'b1, 8'hEE, 1'b0, 4, 8'hAA, 1'b1, 1'b0, 4});
    vecs.push_back('{1'b1, 8'hEE, 1'b1, 3, 8'hBB, 1'b0, 1'b0, 4});
    vecs.push_back('{1'b1, 8'hEE, 1'b0, 4, 8'hBB, 1'b1, 1'b0, 5});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 3, 8'hCC, 1'b0, 1'b0, 5});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 2, 8'hDD, 1'b0, 1'b0, 5});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1, 8'hEE, 1'b0, 1'b0, 5});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 0, 8'h00, 1'b0, 1'b1, 5});
    vecs.push_back('{1'b1, 8'hAA, 1'b0, 1, 8'hAA, 1'b0, 1'b0, 6});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1, 8'hAA, 1'b0, 1'b0, 6});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 0, 8'h00, 1'b0, 1'b1, 6});
    vecs.push_back('{1'b0, 8'h5A, 1'b0, 0, 8'h00, 1'b0, 1'b1, 6});

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].r);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_out_data", i), 32'(bus.out_data), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].exp_full));
      chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(!vecs[i].exp_full));
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
      chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(!vecs[i].exp_empty));
      chk($sformatf("vec%0d_beat_cnt", i), 32'(beat_cnt), 32'(vecs[i].exp_beat));
    end

    // Streaming across two pointer wraps from a fresh reset.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'(8'h55 + i), 1'b1);
      @(posedge clk);
      #1;
      chk($sformatf("stream%0d_count", i), 32'(count), 32'd1);
      chk($sformatf("stream%0d_out_data", i), 32'(bus.out_data), 32'(8'h55 + i));
      chk($sformatf("stream%0d_beat_cnt", i), 32'(beat_cnt), 32'(i + 1));
    end
    drive(1'b0, 8'h00, 1'b1);
    @(posedge clk);
    #1;
    chk("stream_drain_empty", 32'(empty), 32'd1);
    chk("stream_beat_cnt", 32'(beat_cnt), 32'd10);

    // Asynchronous reset mid-stream with three beats stored and a beat on offer.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'h10 + i), 1'b0);
      @(posedge clk);
      #1;
    end
    chk("pre_rst_count", 32'(count), 32'd3);
    drive(1'b1, 8'h77, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_out_data", 32'(bus.out_data), 32'h00);
    chk("arst_beat_cnt", 32'(beat_cnt), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_full", 32'(full), 32'd0);
    @(posedge clk);
    #1;
    chk("arst_no_accept_count", 32'(count), 32'd0);
    chk("arst_no_accept_beat", 32'(beat_cnt), 32'd0);
    drive(1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    mq.delete();
    mbeat = 16'd0;

    // Randomized traffic against the queue model, with varying push/pop pressure.
    for (int i = 0; i < 1500; i++) begin
      int bias;
      bias = (i / 300) % 3;
      model_step(($urandom_range(0, 3) != 0),
                 8'($urandom()),
                 (bias == 0) ? ($urandom_range(0, 3) == 0) :
                 (bias == 1) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
